// File: rtl/sn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sn_pkg
// Description : Shared types, constants and helpers for stochastic-number
//               (SN) bitstream decoders.
// Revision    : 1.0 - initial release
// ============================================================================
package sn_pkg;

    localparam int SN_CNT_W    = 9;  // counters must hold 0..256
    localparam int SN_MAX_LOG2 = 8;  // largest window is 2^8 bits
    localparam int SN_OUT_W    = 8;  // scaled result width

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } sn_state_t;

    // Window length N = 2^(win_sel+1), i.e. 2..256
    function automatic logic [SN_CNT_W-1:0] sn_win_len(input logic [2:0] win_sel);
        sn_win_len = {{(SN_CNT_W-1){1'b0}}, 1'b1} << ({1'b0, win_sel} + 4'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sn_scale.sv
`default_nettype none
// ============================================================================
// Module      : sn_scale
// Description : Combinational scaling of an SN ones-count to an 8-bit value.
//               Unipolar gives an unsigned fraction of 256, bipolar gives a
//               two's complement value in -128..+127; both saturate at the top.
// Revision    : 1.0 - initial release
// ============================================================================
module sn_scale
    import sn_pkg::*;
(
    input  logic [SN_CNT_W-1:0] ones,
    input  logic [3:0]          l,
    input  logic                bipolar,
    output logic [SN_OUT_W-1:0] value
);

    logic [16:0]        w_uni;
    logic [16:0]        w_bip;
    logic signed [17:0] w_t;
    logic signed [17:0] w_half;

    // Shift the count up to full scale, recentre for bipolar, then saturate
    always_comb begin
        w_uni  = {8'd0, ones} << (4'(SN_MAX_LOG2) - l);
        w_bip  = {8'd0, ones} << (4'(SN_MAX_LOG2) + 4'd1 - l);
        w_t    = $signed({1'b0, w_bip}) - 18'sd256;
        w_half = w_t >>> 1;
        value  = '0;
        if (bipolar) begin
            value = (w_half > 18'sd127) ? 8'h7F : w_half[7:0];
        end else begin
            value = (w_uni > 17'd255) ? 8'hFF : w_uni[7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sn_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sn_stream_decoder
// Description : Counts 1s in a serial SN bitstream over a 2..256-bit window
//               and presents count plus scaled value on a valid/ready port.
//               Supports single-shot and gapless continuous windows.
// Revision    : 1.0 - initial release
// ============================================================================
module sn_stream_decoder
    import sn_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cont,
    input  logic [2:0]          win_sel,
    input  logic                bipolar,
    input  logic                sn_valid,
    input  logic                sn_bit,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [SN_CNT_W-1:0] res_count,
    output logic [OUT_W-1:0]    res_value,
    output logic                busy,
    output logic                overrun
);

    sn_state_t             r_state;
    sn_state_t             w_state_nxt;
    logic                  r_cont;
    logic [2:0]            r_win;
    logic                  r_bip;
    logic [SN_CNT_W-1:0]   r_bit_cnt;
    logic [SN_CNT_W-1:0]   r_ones_cnt;
    logic                  r_res_valid;
    logic [SN_CNT_W-1:0]   r_res_count;
    logic [OUT_W-1:0]      r_res_value;
    logic                  r_overrun;

    logic [SN_CNT_W-1:0]   w_bit_inc;
    logic [SN_CNT_W-1:0]   w_ones_inc;
    logic                  w_done;
    logic [3:0]            w_l;
    logic [SN_OUT_W-1:0]   w_scaled;

    assign w_l = {1'b0, r_win} + 4'd1;

    // Scale the count including the current bit, so it is ready to load on completion
    sn_scale u_scale (
        .ones    (w_ones_inc),
        .l       (w_l),
        .bipolar (r_bip),
        .value   (w_scaled)
    );

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and window-completion detect
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_bit_inc   = r_bit_cnt + {{(SN_CNT_W-1){1'b0}}, 1'b1};
        w_ones_inc  = r_ones_cnt + {{(SN_CNT_W-1){1'b0}}, sn_bit};
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (sn_valid && (w_bit_inc == sn_win_len(r_win))) begin
                    w_done = 1'b1;
                    if (!r_cont) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Config capture and window counters
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cont     <= 1'b0;
            r_win      <= 3'd0;
            r_bip      <= 1'b0;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_cont     <= cont;
            r_win      <= win_sel;
            r_bip      <= bipolar;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
        end else if ((r_state == ACCUM) && sn_valid) begin
            if (w_done) begin
                r_bit_cnt  <= '0;
                r_ones_cnt <= '0;
            end else begin
                r_bit_cnt  <= w_bit_inc;
                r_ones_cnt <= w_ones_inc;
            end
        end
    end

    // Result holding register with valid/ready handshake; a completion that
    // finds an unaccepted result is dropped and flagged instead
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_res_valid <= 1'b0;
            r_res_count <= '0;
            r_res_value <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_res_valid || res_ready) begin
                    r_res_valid <= 1'b1;
                    r_res_count <= w_ones_inc;
                    r_res_value <= w_scaled;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_count = r_res_count;
    assign res_value = r_res_value;
    assign busy      = (r_state == ACCUM);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/sn_stream_decoder.md
# sn_stream_decoder

Stochastic-number (SN) bitstream decoder that converts a serial unipolar or bipolar SN stream back to binary. It counts 1s over a programmable window of 2..256 valid bits and presents the result on a valid/ready output. It is the receive end for the LFSR-comparator SN generators and XNOR/AND stochastic multipliers in this design. It replaces the fixed 128-bit free-running up-counter with a window-controlled, handshaked decoder.

## Interface
- OUT_W, 8: width of scaled result `res_value`; fixed at 8, not to be overridden.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a window; ignored unless state is IDLE.
- cont  in  1  continuous mode; sampled with `start`.
- win_sel  in  3  window length N = 2^(win_sel+1), giving L = win_sel+1 and N = 2..256; sampled with `start`.
- bipolar  in  1  1 = bipolar decode, 0 = unipolar; sampled with `start`.
- sn_valid  in  1  `sn_bit` is valid this cycle.
- sn_bit  in  1  stochastic bit.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_count  out  9  number of 1s in the window, range 0..N.
- res_value  out  8  scaled result: unsigned when unipolar, two's complement when bipolar.
- busy  out  1  state is ACCUM.
- overrun  out  1  one-cycle pulse when a result is dropped.

## Operation
- States:
  - IDLE: `start` latches `cont`, `win_sel` and `bipolar` into config registers, clears `bit_cnt` (9b) and `ones_cnt` (9b), and moves to ACCUM.
  - ACCUM: each cycle with `sn_valid` increments `bit_cnt` and adds `sn_bit` to `ones_cnt`.
- Window completion: the cycle in which a valid bit makes `bit_cnt` reach N.
  - The final `ones_cnt`, including that bit, is loaded into the result registers.
  - Counters clear.
  - cont=1: stay in ACCUM with the same config. cont=0: go to IDLE.
- Unipolar scaling: value = ones << (8−L), saturated to 255. Example: N=256 with 256 ones gives 255.
- Bipolar scaling: t = (ones << (9−L)) − 256, a 10b signed value; value = t >>> 1, saturated to +127. Range −128..+127.
- Result handshake:
  - `res_valid` rises on load.
  - `res_valid` falls the cycle after `res_valid & res_ready`, unless a new load occurs in the same cycle.
  - Load and accept in the same cycle: the new result is stored and `res_valid` stays 1.
  - Completion while `res_valid`=1 and `res_ready`=0: the new result is dropped, the held result is unchanged, and `overrun` pulses.
- `start` while busy is ignored and has no effect on config.
- `res_value` and `res_count` are stable while `res_valid`=1.
- Reset (async, any state, including mid-window):
  - state returns to IDLE and all counters and config clear.
  - `res_valid`=0, `res_count`=0, `res_value`=0x00, `busy`=0, `overrun`=0.
  - No partial result is ever emitted.

## Timing
- `start` is sampled at edge T. ACCUM and `busy`=1 are visible after T. `sn_valid` at T itself is not counted.
- A window whose last valid bit is sampled at edge k shows `res_valid`=1 and the result after edge k (1-cycle latency).
- cont=1: a bit sampled at edge k+1 is counted in the next window, with zero gap between windows.
- `busy` falls after edge k when cont=0.
- `overrun` is high for exactly the cycle after edge k.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `sn_pkg` holds:
  - the state enum (IDLE, ACCUM);
  - the constants SN_CNT_W=9, SN_MAX_LOG2=8, SN_OUT_W=8;
  - the window-length function N(win_sel).
- Sub-module `sn_scale` is purely combinational: inputs `ones`[8:0], L, `bipolar`; output `value`[7:0] with saturation. It is reusable by other SN decoders.

## Test plan
- Reset default: assert `rst_n` mid-window after 5 valid bits, then deassert. Required: all outputs 0, state IDLE, no `res_valid`.
- Unipolar, N=16: `win_sel`=3, `bipolar`=0, feed 16 valid bits containing 12 ones with `sn_valid` gaps. Required: `res_count`=12, `res_value`=192, `res_valid` exactly one cycle after the 16th bit.
- Bipolar saturation, N=256 (`win_sel`=7):
  - all ones: `res_count`=256, `res_value`=0x7F;
  - all zeros: 0x80;
  - exactly 128 ones: 0x00.
- Continuous back-to-back, N=4, `cont`=1, `res_ready`=1, `sn_valid` held at 1, pattern 1111 0000 1010. Required: results 4/255, 0/0, 2/128 on consecutive 4-cycle boundaries. `busy` stays high throughout.
- Overrun, N=2, `cont`=1, `res_ready`=0, 4 valid bits. Required: first result held unchanged, `overrun` pulses once at the second completion. `res_ready`=1 on the same cycle as a completion: new result loads and `res_valid` stays high.
- `start` while busy with a different `win_sel`: ignored, and the window length is unchanged.
